// File: rtl/reply_scheduler.sv
// Round-robin reply scheduler: frames one source's reply as SYNC, ADDR, LEN, payload, CSUM to the UART stream.
// Latency: request seen in IDLE -> SYNC valid next cycle; stalls on !tx_ready with tx_data held, pops only on transfer.
module reply_scheduler #(
  parameter int          N_SRC = 25,
  parameter logic [7:0]  SYNC  = 8'h55
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_SRC-1:0]     have_msg_bus,
  input  logic [8*N_SRC-1:0]   len_bus,
  input  logic [8*N_SRC-1:0]   data_bus,
  output logic [N_SRC-1:0]     rdreq_bus,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic [7:0]           grant_idx,
  output logic                 frame_done
);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_ADDR, S_LEN, S_DATA, S_CSUM} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] ptr;
  logic [7:0] len;
  logic [7:0] cnt;
  logic [7:0] csum;
  logic [7:0] hdr_byte;
  logic       found;
  logic [7:0] sel_idx;
  logic [7:0] sel_len;
  logic [7:0] cur_byte;
  logic       xfer;

  // First pass covers ptr..N_SRC-1, second pass wraps to the low indices.
  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (!found && have_msg_bus[i] && (8'(i) >= ptr)) begin
        found   = 1'b1;
        sel_idx = 8'(i);
      end
    end
    for (int i = 0; i < N_SRC; i++) begin
      if (!found && have_msg_bus[i]) begin
        found   = 1'b1;
        sel_idx = 8'(i);
      end
    end
  end

  always_comb begin
    sel_len  = '0;
    cur_byte = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (sel_idx == 8'(i))   sel_len  = len_bus[8*i +: 8];
      if (grant_idx == 8'(i)) cur_byte = data_bus[8*i +: 8];
    end
  end

  // Outputs are gated by rst so nothing leaves the block during the reset cycle itself.
  assign busy     = !rst && (state != S_IDLE);
  assign tx_valid = busy;
  assign xfer     = tx_valid && tx_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (found) state_nxt = S_SYNC;
      S_SYNC: if (xfer)  state_nxt = S_ADDR;
      S_ADDR: if (xfer)  state_nxt = S_LEN;
      S_LEN:  if (xfer)  state_nxt = (len == 8'd0) ? S_CSUM : S_DATA;
      S_DATA: if (xfer && (cnt == 8'd1)) state_nxt = S_CSUM;
      S_CSUM: if (xfer)  state_nxt = S_IDLE;
      default:           state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    tx_data    = '0;
    rdreq_bus  = '0;
    frame_done = 1'b0;
    if (!rst) begin
      case (state)
        S_SYNC, S_ADDR, S_LEN: tx_data = hdr_byte;
        S_DATA: begin
          tx_data = cur_byte;
          if (tx_ready) rdreq_bus = N_SRC'(1) << grant_idx;
        end
        S_CSUM: begin
          tx_data    = csum;
          frame_done = tx_ready;
        end
        default: tx_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_idx <= '0;
      len       <= '0;
      cnt       <= '0;
      csum      <= '0;
      ptr       <= '0;
      hdr_byte  <= '0;
    end else begin
      case (state)
        S_IDLE: if (found) begin
          grant_idx <= sel_idx;
          len       <= sel_len;
          csum      <= '0;
          hdr_byte  <= SYNC;
        end
        S_SYNC: if (xfer) hdr_byte <= grant_idx;
        S_ADDR: if (xfer) begin
          csum     <= csum ^ grant_idx;
          hdr_byte <= len;
        end
        S_LEN: if (xfer) begin
          csum <= csum ^ len;
          cnt  <= len;
        end
        S_DATA: if (xfer) begin
          csum <= csum ^ cur_byte;
          cnt  <= cnt - 8'd1;
        end
        S_CSUM: if (xfer) ptr <= (grant_idx == 8'(N_SRC-1)) ? 8'd0 : grant_idx + 8'd1;
        default: ;
      endcase
    end
  end

endmodule
